// File: rtl/progmem_mc_port_pkg.sv
// Shared constants and helpers for the multi-channel program memory port.
package progmem_mc_port_pkg;

    localparam int unsigned INST_W_DEF      = 32;
    localparam int unsigned INST_ADDR_W_DEF = 32;
    localparam int unsigned PROGMEM_DEPTH   = 1024;
    localparam logic [31:0] INST_NOP        = 32'h0000_0013;

    // Width of an index into n items, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/progmem_mc_port_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, search starting at
// the channel after the last one granted.
module rr_arbiter
    import progmem_mc_port_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = id_width(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;
    logic          found;

    // Pick the first requester at or above ptr, then wrap to those below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (en && !found && req[i] && (PW'(i) >= ptr)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = PW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (en && !found && req[i] && (PW'(i) < ptr)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = PW'(i);
            end
        end
    end

    // Pointer holds the next search start; it only moves on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/progmem_mc_port.sv
// Shared instruction memory with N_CORES fetch channels, round-robin
// arbitration, a LATENCY-deep read pipeline and a preload write port.
module progmem_mc_port
    import progmem_mc_port_pkg::*;
#(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned DEPTH   = PROGMEM_DEPTH,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned INST_W  = INST_W_DEF,
    parameter int unsigned ADDR_W  = INST_ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CORES-1:0]          core_req,
    input  logic [N_CORES*ADDR_W-1:0]   core_addr,
    output logic [N_CORES*INST_W-1:0]   core_data,
    output logic [N_CORES-1:0]          core_valid,
    output logic [N_CORES-1:0]          core_err,
    input  logic                        load_we,
    input  logic [ADDR_W-1:0]           load_addr,
    input  logic [INST_W-1:0]           load_data
);

    localparam int unsigned CH_W  = id_width(N_CORES);
    localparam int unsigned IDX_W = id_width(DEPTH);
    localparam int unsigned LAST  = LATENCY - 1;

    logic [INST_W-1:0]  mem [DEPTH];

    logic [N_CORES-1:0] outstanding;
    logic [N_CORES-1:0] eligible;
    logic [N_CORES-1:0] grant;
    logic [N_CORES-1:0] resp_mask;

    logic [ADDR_W-1:0]  sel_addr;
    logic [ADDR_W-1:0]  sel_word;
    logic [CH_W-1:0]    sel_id;
    logic               sel_err;

    logic [ADDR_W-1:0]  load_word;
    logic               load_ok;

    logic [LATENCY-1:0] pipe_vld;
    logic [LATENCY-1:0] pipe_err;
    logic [CH_W-1:0]    pipe_id  [LATENCY];
    logic [IDX_W-1:0]   pipe_idx [LATENCY];

    assign eligible = core_req & ~outstanding;

    rr_arbiter #(
        .N (N_CORES)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (eligible),
        .en    (~load_we),
        .grant (grant)
    );

    // Decode the one-hot grant into the granted channel's address and id.
    always_comb begin
        sel_addr = '0;
        sel_id   = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (grant[i]) begin
                sel_addr = core_addr[i*ADDR_W +: ADDR_W];
                sel_id   = CH_W'(i);
            end
        end
    end

    assign sel_word  = sel_addr >> 2;
    assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_word >= ADDR_W'(DEPTH));
    assign load_word = load_addr >> 2;
    assign load_ok   = (load_addr[1:0] == 2'b00) && (load_word < ADDR_W'(DEPTH));

    // Channels whose response leaves the pipeline on the coming edge.
    always_comb begin
        resp_mask = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (pipe_vld[LAST] && (pipe_id[LAST] == CH_W'(i))) begin
                resp_mask[i] = 1'b1;
            end
        end
    end

    // Preload writes; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (load_we && load_ok) begin
            mem[load_word[IDX_W-1:0]] <= load_data;
        end
    end

    // Outstanding flags and the issue pipeline; a channel is never granted
    // while outstanding, so set and clear never hit the same bit together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            pipe_vld    <= '0;
            pipe_err    <= '0;
            for (int unsigned s = 0; s < LATENCY; s++) begin
                pipe_id[s]  <= '0;
                pipe_idx[s] <= '0;
            end
        end else begin
            outstanding <= (outstanding & ~resp_mask) | grant;
            pipe_vld[0] <= |grant;
            pipe_err[0] <= sel_err;
            pipe_id[0]  <= sel_id;
            pipe_idx[0] <= sel_word[IDX_W-1:0];
            for (int unsigned s = 1; s < LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_err[s] <= pipe_err[s-1];
                pipe_id[s]  <= pipe_id[s-1];
                pipe_idx[s] <= pipe_idx[s-1];
            end
        end
    end

    // Per-channel response registers; data holds between valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_valid <= '0;
            core_err   <= '0;
            core_data  <= '0;
        end else begin
            core_valid <= resp_mask;
            for (int unsigned i = 0; i < N_CORES; i++) begin
                if (resp_mask[i]) begin
                    core_err[i] <= pipe_err[LAST];
                    core_data[i*INST_W +: INST_W] <= pipe_err[LAST] ? INST_W'(INST_NOP)
                                                                    : mem[pipe_idx[LAST]];
                end
            end
        end
    end

endmodule

// File: tb/tb_progmem_mc_port.sv
// Directed bench for progmem_mc_port: a 4-channel and a 1-channel instance.
module tb_progmem_mc_port;

    localparam int unsigned NC = 4;
    localparam int unsigned IW = 32;
    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-channel instance signals
    logic [NC-1:0]    req4;
    logic [NC*AW-1:0] addr4;
    logic [NC*IW-1:0] data4;
    logic [NC-1:0]    valid4;
    logic [NC-1:0]    err4;
    logic             we4;
    logic [AW-1:0]    laddr4;
    logic [IW-1:0]    ldata4;
    logic [31:0]      a4 [NC];
    logic [31:0]      d4 [NC];

    // 1-channel instance signals
    logic [0:0]       req1;
    logic [AW-1:0]    addr1;
    logic [IW-1:0]    data1;
    logic [0:0]       valid1;
    logic [0:0]       err1;
    logic             we1;
    logic [AW-1:0]    laddr1;
    logic [IW-1:0]    ldata1;

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < NC; g++) begin : g_view
        assign addr4[g*AW +: AW] = a4[g];
        assign d4[g]             = data4[g*IW +: IW];
    end

    progmem_mc_port #(
        .N_CORES (4),
        .DEPTH   (1024),
        .LATENCY (2)
    ) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (req4),
        .core_addr  (addr4),
        .core_data  (data4),
        .core_valid (valid4),
        .core_err   (err4),
        .load_we    (we4),
        .load_addr  (laddr4),
        .load_data  (ldata4)
    );

    progmem_mc_port #(
        .N_CORES (1),
        .DEPTH   (1024),
        .LATENCY (2)
    ) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (req1),
        .core_addr  (addr1),
        .core_data  (data1),
        .core_valid (valid1),
        .core_err   (err1),
        .load_we    (we1),
        .load_addr  (laddr1),
        .load_data  (ldata1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single fetch on the 4-channel instance, optionally with a preload write
    // in the first cycle. cyc counts edges from request to valid.
    task automatic fetch(input logic [1:0] ch, input logic [31:0] a, input logic do_load,
                         input logic [31:0] la, input logic [31:0] ld,
                         output logic [31:0] d, output logic e, output int cyc);
        a4[ch]   = a;
        req4[ch] = 1'b1;
        if (do_load) begin
            we4    = 1'b1;
            laddr4 = la;
            ldata4 = ld;
        end
        cyc = 0;
        d   = '0;
        e   = 1'b0;
        while (cyc < 20) begin
            tick();
            we4 = 1'b0;
            cyc++;
            if (valid4[ch]) begin
                d = d4[ch];
                e = err4[ch];
                break;
            end
        end
        req4[ch] = 1'b0;
        if (cyc >= 20) check("fetch_timeout", 64'(valid4[ch]), 1);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          cyc;
        logic [1:0]  ch;
        int          c0, c2, last, cur, k2;

        rst_n  = 1'b0;
        req4   = '0;
        we4    = 1'b0;
        laddr4 = '0;
        ldata4 = '0;
        req1   = '0;
        addr1  = '0;
        we1    = 1'b0;
        laddr1 = '0;
        ldata1 = '0;
        for (int i = 0; i < NC; i++) a4[i] = '0;

        // Reset state
        tick();
        tick();
        check("reset_valid4", 64'(valid4), 0);
        check("reset_err4", 64'(err4), 0);
        check("reset_data4", 64'(|data4), 0);
        check("reset_valid1", 64'(valid1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Preload mem[i]=0x100+i on the 4-ch instance, word 5 on the 1-ch instance
        for (int i = 0; i < 4; i++) begin
            we4    = 1'b1;
            laddr4 = 32'(4 * i);
            ldata4 = 32'h100 + 32'(i);
            if (i == 0) begin
                we1    = 1'b1;
                laddr1 = 32'h14;
                ldata1 = 32'h00A0_0193;
            end
            tick();
            we1 = 1'b0;
        end
        we4 = 1'b0;

        // Contention: all four request together, grants 0..3, valids two edges later
        for (int i = 0; i < NC; i++) a4[i] = 32'(4 * i);
        req4 = 4'hF;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("cont_valid", 64'(valid4), (k < 2) ? 64'd0 : 64'(1 << (k - 2)));
            if (k >= 2) begin
                ch = 2'(k - 2);
                check("cont_data", 64'(d4[ch]), 64'(32'h100 + 32'(k - 2)));
                check("cont_err", 64'(err4), 0);
                req4[ch] = 1'b0;
            end
        end
        tick();
        tick();

        // Fairness: channels 0 and 2 request continuously for 40 cycles
        a4[0] = 32'h0;
        a4[2] = 32'h8;
        req4  = 4'b0101;
        c0    = 0;
        c2    = 0;
        last  = -1;
        for (int k = 0; k < 44; k++) begin
            tick();
            if (k == 39) req4 = '0;
            if (valid4 != '0) begin
                cur = -1;
                if (valid4 == 4'b0001) begin
                    cur = 0;
                    c0++;
                    check("fair_data0", 64'(d4[0]), 64'h100);
                end else if (valid4 == 4'b0100) begin
                    cur = 2;
                    c2++;
                    check("fair_data2", 64'(d4[2]), 64'h102);
                end else begin
                    check("fair_onehot", 64'(valid4), 64'b0001);
                end
                if (last >= 0) check("fair_alternate", 64'(cur), 64'(2 - last));
                last = cur;
            end
        end
        k2 = (c0 > c2) ? (c0 - c2) : (c2 - c0);
        check("fair_balance", 64'(k2 <= 1), 1);
        check("fair_count0", 64'(c0), 14);
        check("fair_count2", 64'(c2), 13);

        // Errors: out of range, misaligned; then memory unchanged
        fetch(2'd0, 32'h1000, 1'b0, '0, '0, d, e, cyc);
        check("err_range_flag", 64'(e), 1);
        check("err_range_data", 64'(d), 64'h13);
        check("err_range_lat", 64'(cyc), 3);
        fetch(2'd0, 32'h6, 1'b0, '0, '0, d, e, cyc);
        check("err_align_flag", 64'(e), 1);
        check("err_align_data", 64'(d), 64'h13);
        fetch(2'd0, 32'h0, 1'b0, '0, '0, d, e, cyc);
        check("good_flag", 64'(e), 0);
        check("good_data0", 64'(d), 64'h100);
        check("good_lat", 64'(cyc), 3);
        fetch(2'd1, 32'h4, 1'b0, '0, '0, d, e, cyc);
        check("good_data1", 64'(d), 64'h101);

        // Load priority: write and read of the same word in the same cycle
        fetch(2'd1, 32'h8, 1'b1, 32'h8, 32'hDEAD_BEEF, d, e, cyc);
        check("load_data", 64'(d), 64'hDEAD_BEEF);
        check("load_lat", 64'(cyc), 4);
        check("load_err", 64'(e), 0);
        // Misaligned write is dropped but still blocks the grant
        fetch(2'd1, 32'h8, 1'b1, 32'h9, 32'h1234_5678, d, e, cyc);
        check("load_mis_data", 64'(d), 64'hDEAD_BEEF);
        check("load_mis_lat", 64'(cyc), 4);

        // Reset mid-flight
        for (int i = 0; i < NC; i++) a4[i] = 32'(4 * i);
        req4 = 4'hF;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        req4  = '0;
        #1;
        check("midrst_valid", 64'(valid4), 0);
        check("midrst_err", 64'(err4), 0);
        check("midrst_data", 64'(|data4), 0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("midrst_quiet", 64'(valid4), 0);
        end
        req4 = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (valid4 != '0) break;
        end
        check("midrst_first", 64'(valid4), 64'b0001);
        req4[0] = 1'b0;
        for (int k = 0; k < 20 && req4 != '0; k++) begin
            tick();
            req4 = req4 & ~valid4;
        end
        check("midrst_drain", 64'(req4), 0);
        tick();
        tick();

        // Single channel: req held on 0x14, valid every third edge
        addr1 = 32'h14;
        req1  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("single_valid", 64'(valid1), 64'((k % 3) == 0));
            if (valid1[0]) begin
                check("single_data", 64'(data1), 64'h00A0_0193);
                check("single_err", 64'(err1), 0);
            end
        end
        req1 = '0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/progmem_mc_port.md
Name: progmem_mc_port

Overview:
- Parametrised shared instruction memory serving N_CORES fetch channels.
- Generalises the single `progmem_addr`/`progmem_data` fetch path into a multi-channel, pipelined read port with round-robin arbitration and configurable read latency.
- Adds error signalling for out-of-range and misaligned fetches, plus a write/preload port for benches and boot code.
- Sits between the CORE instances and the program store in the multicore top level.

Parameters:
- N_CORES, 4, number of fetch channels (1..16).
- DEPTH, 1024, memory size in 32-bit words.
- LATENCY, 2, cycles from grant to response (>=1).
- INST_W, `INST_W (32), instruction width.
- ADDR_W, `INST_ADDR_W, byte-address width per channel.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- core_req  in  N_CORES  per-channel fetch request.
- core_addr  in  N_CORES*ADDR_W  flattened byte addresses; channel i at [i*ADDR_W +: ADDR_W].
- core_data  out  N_CORES*INST_W  flattened fetched instructions.
- core_valid  out  N_CORES  one-cycle response pulse per channel.
- core_err  out  N_CORES  error flag, qualified by core_valid.
- load_we  in  1  preload write enable.
- load_addr  in  ADDR_W  preload byte address.
- load_data  in  INST_W  preload word.

Behaviour:
- Reset (rst_n=0, async) clears:
  - round-robin pointer to 0;
  - all outstanding flags;
  - all pipeline valid bits;
  - core_valid, core_err and core_data to 0.
- Memory contents are not reset.
- Reset mid-flight discards all in-flight responses; no valid is produced for them.
- Eligibility: channel i is eligible when core_req[i]=1 and outstanding[i]=0.
- Arbitration, once per cycle:
  - At most one eligible channel is granted.
  - Search starts at the channel after the last granted one, wrapping modulo N_CORES.
  - The pointer updates only on a grant.
- On grant at edge T:
  - outstanding[i] is set.
  - Address and channel id enter a LATENCY-deep pipeline; one issue per cycle, fully pipelined.
- Response at edge T+LATENCY:
  - core_valid[i]=1 for exactly one cycle.
  - core_data[i] is loaded with the fetched word.
  - outstanding[i] is cleared.
- Requester rules:
  - core_req[i] and core_addr[i] must stay stable until the matching valid.
  - core_addr is sampled at grant.
  - If req drops while outstanding, the response is still delivered.
- Back-to-back fetch: req sampled high in the same cycle core_valid[i] is high counts as a new request. Per-channel peak rate is one fetch per LATENCY+1 cycles.
- core_data[i] holds its last value between valids.
- Word index = addr>>2. Error case: addr[1:0]!=0 or index>=DEPTH gives:
  - core_err[i]=1 with the valid;
  - core_data[i]=`INST_NOP (0x00000013);
  - no memory access.
- core_err[i]=0 on every good response.
- load_we=1:
  - Writes load_data at load_addr>>2 on that edge; out-of-range or misaligned writes are dropped.
  - No grant is issued that cycle; in-flight reads continue.
- A read granted in the cycle after a write to the same index returns the new data.
- Single-channel configuration (N_CORES=1) reduces to always-grant when eligible.

Decomposition:
- Additions to defines.vh:
  - `INST_NOP encoding;
  - `PROGMEM_DEPTH default;
  - channel-id width macro $clog2(N_CORES), minimum 1.
- Sub-module rr_arbiter (parametrised N): takes req vector and enable, produces one-hot grant, holds the pointer.
- Memory array, latency pipeline and per-channel response registers stay in progmem_mc_port.

Test Plan:
- Single channel, N_CORES=1, LATENCY=2:
  - Stimulus: word 5=0x00A00193, req held high on addr 0x14.
  - Response: valid pulses every 3 cycles with data 0x00A00193 and err=0.
- Contention, N_CORES=4:
  - Stimulus: all req rise together, channel i addr=4*i, mem[i]=0x100+i.
  - Response: grants at cycles 0,1,2,3 in order 0,1,2,3; valids at 2,3,4,5 with matching data.
- Fairness:
  - Stimulus: channels 0 and 2 request continuously for 40 cycles.
  - Response: grants strictly alternate; grant counts differ by <=1.
- Errors:
  - Stimulus: addr=4*DEPTH, then addr=0x6.
  - Response: each gives valid with err=1 and data=0x00000013; memory unchanged.
- Load priority:
  - Stimulus: load_we=1 writing 0xDEADBEEF to 0x8 while channel 1 requests 0x8.
  - Response: no grant in the write cycle; channel 1 receives 0xDEADBEEF one cycle later than unloaded timing.
- Reset mid-flight:
  - Stimulus: deassert rst_n with 3 reads in flight.
  - Response: all valid/err/data go 0 immediately; no stale valid after release; the first post-reset grant goes to channel 0.
